serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer driving an external full adder, LSB first.
// Operands are captured on start; the result appears after WIDTH cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] s_nxt;

  assign last  = (cnt == LAST);
  assign s_nxt = {fa_sum, s_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    unique case (state)
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = c_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // sum/cout only ever load the completed word, never a partial one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      c_q  <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= op_a;
      b_sr <= op_b;
      c_q  <= cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= s_nxt;
      c_q  <= fa_cout;
      cnt  <= cnt + CW'(1);
      if (last) begin
        sum  <= s_nxt;
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random bench for serial_adder_ctrl with a behavioural
// full adder; results are scored against a queue of expected sums.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int accepted = 0;
  logic [W:0] held = '0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    accepted++;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Scoreboard: pop on done, otherwise the result must hold steady
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!busy) chk("fa_idle_zero", {fa_a, fa_b, fa_cin}, 0);
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          held = sb.pop_front();
          chk("result", {cout, sum}, held);
        end
      end else begin
        chk("hold", {cout, sum}, held);
      end
    end
  end

  initial begin
    int d0;
    int a0;
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 8'h5A;
    op_b  = 8'h3C;
    cin   = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", {cout, sum}, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);

    // first edge out of reset accepts the held start
    rst_n = 1'b1;
    sb.push_back(9'h096);
    accepted++;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("busy_run%0d", i), busy, 1);
      tick();
    end
    chk("done_at_w", done, 1);
    chk("busy_at_done", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    wait_done();

    start_op(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("fa_cin%0d", i), fa_cin, (i == 0) ? 0 : 1);
      tick();
    end
    wait_done();

    // back-to-back with start held through DONE
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    sb.push_back(9'h1FF);
    sb.push_back(9'h000);
    accepted += 2;
    tick();
    op_a = 8'h00;
    op_b = 8'h00;
    cin  = 1'b0;
    repeat (W) tick();
    chk("b2b_done1", done, 1);
    repeat (2) tick();
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    repeat (W - 1) tick();
    chk("b2b_early", done, 0);
    tick();
    chk("b2b_done2", done, 1);
    wait_done();

    d0 = done_cnt;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) tick();
    op_a  = 8'hAA;
    op_b  = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    repeat (3) tick();
    chk("single_done", done_cnt - d0, 1);

    // abort mid-run
    start_op(8'h80, 8'h80, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    held  = '0;
    d0 = done_cnt;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", {cout, sum}, 0);
    repeat (12) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    start_op(8'h80, 8'h80, 1'b0);
    wait_done();

    d0 = done_cnt;
    a0 = accepted;
    for (int i = 0; i < 1000; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
    end
    chk("rand_done_count", done_cnt - d0, accepted - a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
